// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: 32 RUN cycles then a one-cycle valid pulse.
// Divide-by-zero and signed overflow resolve in one cycle; busy stalls issue, start is ignored outside IDLE.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  dq_q, dq_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic [4:0]       rd_out_q, rd_out_d;
    logic             sel_rem_q, sel_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             is_signed;
    logic             is_ovf;
    logic [XLEN-1:0]  mag1, mag2;
    logic [XLEN:0]    rem_shift, trial;
    logic [XLEN-1:0]  r_next, dq_next;
    logic [XLEN-1:0]  q_fin, r_fin;

    // dq_q holds the dividend shifting out of the top while quotient bits shift in at the bottom
    always_comb begin
        is_signed = !op[0];
        is_ovf    = is_signed && (rs1 == MIN_NEG) && (rs2 == '1);
        mag1      = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
        mag2      = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;

        rem_shift = {rem_q, dq_q[XLEN-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        if (!trial[XLEN]) begin
            r_next  = trial[XLEN-1:0];
            dq_next = {dq_q[XLEN-2:0], 1'b1};
        end else begin
            r_next  = rem_shift[XLEN-1:0];
            dq_next = {dq_q[XLEN-2:0], 1'b0};
        end
        q_fin = q_neg_q ? -dq_next : dq_next;
        r_fin = r_neg_q ? -r_next  : r_next;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dq_d      = dq_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        result_d  = result_q;
        rd_d      = rd_q;
        rd_out_d  = rd_out_q;
        sel_rem_d = sel_rem_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    rd_d      = rd_in;
                    sel_rem_d = op[1];
                    if (rs2 == '0) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = op[1] ? rs1 : '1;
                        rd_out_d = rd_in;
                    end else if (is_ovf) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = op[1] ? '0 : MIN_NEG;
                        rd_out_d = rd_in;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        dq_d    = mag1;
                        dvs_d   = mag2;
                        rem_d   = '0;
                        q_neg_d = is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        r_neg_d = is_signed && rs1[XLEN-1];
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    dq_d  = dq_next;
                    rem_d = r_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        valid_d  = 1'b1;
                        result_d = sel_rem_q ? r_fin : q_fin;
                        rd_out_d = rd_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dq_q      <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            rd_out_q  <= '0;
            sel_rem_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dq_q      <= dq_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            rd_out_q  <= rd_out_d;
            sel_rem_q <= sel_rem_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against a plain-arithmetic RV32M division model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errs = 0;
    int checks = 0;

    div_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension semantics straight from the ISA rules
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Drives one start pulse; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Issues and observes 40 cycles: edges-to-valid, captured result/tag, busy and valid cycle counts.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int lat, output logic [31:0] res, output logic [4:0] rdo,
                         output int busy_cnt, output int vld_cnt);
        issue(o, a, b, rd);
        lat = -1; res = 'x; rdo = 'x; busy_cnt = 0; vld_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_cnt++;
            if (valid) begin
                vld_cnt++;
                if (lat < 0) begin
                    lat = n; res = result; rdo = rd_out;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (result !== 32'd0) begin errs++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (rd_out !== 5'd0) begin errs++; $display("FAIL reset_rd_out got=%h exp=0", rd_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [10] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
        logic [31:0] t_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd5,
                                    32'hFFFF_FFF7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [10] = '{32'd7, 32'd7, 32'd3, 32'd3, 32'hFFFF_FFFD, 32'd0, 32'd0,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF,
                                    32'hFFFF_FFF7, 32'h8000_0000, 32'd0, 32'd0};
        int          t_lat [10] = '{32, 32, 32, 32, 32, 0, 0, 0, 0, 32};
        int lat, bc, vc;
        logic [31:0] res;
        logic [4:0] rdo;
        for (int i = 0; i < 10; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 5'(i + 3), lat, res, rdo, bc, vc);
            checks++; if (res !== t_exp[i]) begin errs++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, t_exp[i]); end
            checks++; if (lat !== t_lat[i]) begin errs++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, t_lat[i]); end
            checks++; if (bc !== t_lat[i]) begin errs++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, t_lat[i]); end
            checks++; if (vc !== 1) begin errs++; $display("FAIL dir%0d_valid_cycles got=%0d exp=1", i, vc); end
            checks++; if (rdo !== 5'(i + 3)) begin errs++; $display("FAIL dir%0d_rd_out got=%0d exp=%0d", i, rdo, i + 3); end
        end
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'(int'($urandom_range(0, 60)) - 30);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, res;
        logic [4:0]  rd, rdo;
        int lat, bc, vc;
        for (int i = 0; i < 30; i++) begin
            o  = 2'($urandom_range(0, 3));
            a  = pick($urandom_range(0, 5));
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick($urandom_range(0, 5));
            rd = 5'($urandom);
            do_op(o, a, b, rd, lat, res, rdo, bc, vc);
            checks++; if (res !== model(o, a, b)) begin errs++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, res, model(o, a, b)); end
            checks++; if (lat !== model_lat(o, a, b)) begin errs++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, model_lat(o, a, b)); end
            checks++; if (bc !== model_lat(o, a, b)) begin errs++; $display("FAIL rnd%0d_busy_cycles got=%0d exp=%0d", i, bc, model_lat(o, a, b)); end
            checks++; if (vc !== 1) begin errs++; $display("FAIL rnd%0d_valid_cycles got=%0d exp=1", i, vc); end
            checks++; if (rdo !== rd) begin errs++; $display("FAIL rnd%0d_rd_out got=%0d exp=%0d", i, rdo, rd); end
        end
    endtask

    task automatic test_flush();
        int vc, lat, bc;
        logic [31:0] res;
        logic [4:0] rdo;
        issue(2'b01, 32'd123456, 32'd11, 5'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin errs++; $display("FAIL flush_valid got=%b exp=0", valid); end
        vc = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (valid) vc++;
        end
        checks++; if (vc !== 0) begin errs++; $display("FAIL flush_no_result got=%0d valid cycles exp=0", vc); end
        do_op(2'b01, 32'd9, 32'd2, 5'd12, lat, res, rdo, bc, vc);
        checks++; if (res !== 32'd4) begin errs++; $display("FAIL flush_after_result got=%h exp=4", res); end
        checks++; if (lat !== 32) begin errs++; $display("FAIL flush_after_latency got=%0d exp=32", lat); end
        checks++; if (rdo !== 5'd12) begin errs++; $display("FAIL flush_after_rd got=%0d exp=12", rdo); end
    endtask

    task automatic test_start_in_run();
        int lat, vc;
        logic [31:0] res;
        logic [4:0] rdo;
        issue(2'b01, 32'd1000, 32'd7, 5'd3);
        lat = -1; vc = 0; res = 'x; rdo = 'x;
        for (int n = 0; n < 45; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (valid) begin
                vc++;
                if (lat < 0) begin
                    lat = n; res = result; rdo = rd_out;
                end
            end
            if (n == 5) begin
                op = 2'b10; rs1 = 32'd55; rs2 = 32'd0; rd_in = 5'd9; start = 1'b1;
            end
            if (n == 6) start = 1'b0;
        end
        checks++; if (res !== 32'd142) begin errs++; $display("FAIL run_start_result got=%h exp=%h", res, 32'd142); end
        checks++; if (lat !== 32) begin errs++; $display("FAIL run_start_latency got=%0d exp=32", lat); end
        checks++; if (rdo !== 5'd3) begin errs++; $display("FAIL run_start_rd got=%0d exp=3", rdo); end
        checks++; if (vc !== 1) begin errs++; $display("FAIL run_start_valid_cycles got=%0d exp=1", vc); end
    endtask

    task automatic test_done_start();
        int vc;
        // Hold start across the accept edge and the DONE edge; the DONE-cycle start must be ignored.
        @(negedge clk);
        op = 2'b01; rs1 = 32'd5; rs2 = 32'd0; rd_in = 5'd1; start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        vc = 0;
        for (int n = 0; n < 10; n++) begin
            if (valid) vc++;
            @(posedge clk);
            #1;
        end
        checks++; if (vc !== 0) begin errs++; $display("FAIL done_start_ignored got=%0d extra valid cycles exp=0", vc); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, vc;
        logic [31:0] res;
        logic [4:0] rdo;
        issue(2'b00, 32'hFFFF_0000, 32'd13, 5'd21);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin errs++; $display("FAIL midrst_valid got=%b exp=0", valid); end
        checks++; if (result !== 32'd0) begin errs++; $display("FAIL midrst_result got=%h exp=0", result); end
        checks++; if (rd_out !== 5'd0) begin errs++; $display("FAIL midrst_rd_out got=%0d exp=0", rd_out); end
        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd30, lat, res, rdo, bc, vc);
        checks++; if (res !== model(2'b10, 32'hFFFF_FF9C, 32'd7)) begin errs++; $display("FAIL midrst_after_result got=%h exp=%h", res, model(2'b10, 32'hFFFF_FF9C, 32'd7)); end
        checks++; if (lat !== 32) begin errs++; $display("FAIL midrst_after_latency got=%0d exp=32", lat); end
        checks++; if (bc !== 32) begin errs++; $display("FAIL midrst_after_busy got=%0d exp=32", bc); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_in_run();
        test_done_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative radix-2 divider implementing RV32M DIV, DIVU, REM and REMU for the pipelined RV32IM core. Sits directly downstream of the ID/EX pipeline register, alongside the single-cycle ALU and multiplier. The execute stage issues one operation and stalls upstream while busy is high. It then writes the result back through the EX/MEM register when valid pulses.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (2^CNT_W = XLEN)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  issue request; sampled only in IDLE
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1  input  32  dividend
rs2  input  32  divisor
rd_in  input  5  destination register tag, carried through
flush  input  1  pipeline flush; abort in-flight op
busy  output  1  high while an operation is iterating
valid  output  1  one-cycle pulse: result/rd_out valid
result  output  32  quotient or remainder per op
rd_out  output  5  tag latched at start

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, valid=0, result=0, rd_out=0; counter and internal registers cleared. This applies from any state, mid-operation included. rst has priority over flush and start.
- States: IDLE, RUN, DONE.
- IDLE: at an edge with start=1 and flush=0, latch op, rd_in and operand magnitudes. Signed ops (op[0]=0) take abs() of each operand and record the quotient sign (rs1[31]^rs2[31]) and remainder sign (rs1[31]). Unsigned ops use raw operands.
  - Special case rs2==0: go to DONE. Quotient=32'hFFFFFFFF; remainder=rs1 (unmodified).
  - Special case signed overflow (op=DIV/REM, rs1=32'h80000000, rs2=32'hFFFFFFFF): go to DONE. Quotient=32'h80000000; remainder=0.
  - Otherwise: go to RUN with counter=0 and busy=1.
- RUN: restoring division, one quotient bit per cycle, MSB first.
  - Datapath: 33-bit partial remainder; shift left, bring in the next dividend bit, trial-subtract the divisor.
  - If the trial result is non-negative, keep it and shift a 1 into the quotient; else shift a 0.
  - Exactly 32 RUN cycles; on the edge where counter==31, go to DONE.
- DONE: valid=1 for exactly one cycle; busy=0.
  - result = quotient (op[1]=0) or remainder (op[1]=1). Signed ops negate by the recorded sign, with the sign applied at DONE entry so result is registered.
  - rd_out = latched tag. Next edge returns to IDLE. start during DONE is ignored.
- Latency: start edge E0.
  - Normal op: busy high after E0 through E32; valid high for the cycle after E32 (33 cycles after E0).
  - Special cases: valid high for the cycle after E0; busy never asserts.
- result and rd_out hold their last values after valid drops until the next DONE; downstream must qualify them with valid.
- flush=1 at an edge in RUN or DONE: go to IDLE, busy=0, valid=0 on the next cycle, and no result is delivered. In IDLE, flush suppresses acceptance of a simultaneous start.
- start while in RUN: ignored, with no effect on the in-flight op. Issue logic must hold start until busy=0 and valid has been observed.
- Arithmetic: abs(-2^31) stays in a 32-bit unsigned magnitude without overflow. Negation is two's complement modulo 2^32. The remainder sign always follows the dividend (RISC-V semantics).

Test Plan:
- DIVU rs1=100, rs2=7, start one cycle -> busy high 32 cycles, valid pulses exactly 33 cycles after start edge, result=14; same with REMU -> result=2; rd_out equals rd_in given at start.
- DIV rs1=-20 (32'hFFFFFFEC), rs2=3 -> result=32'hFFFFFFFA (-6); REM same operands -> 32'hFFFFFFFE (-2); REM rs1=20, rs2=-3 -> 2.
- Divide by zero: DIVU rs1=5, rs2=0 -> valid one cycle after start, result=32'hFFFFFFFF, busy stays 0; REM rs1=-9, rs2=0 -> result=32'hFFFFFFF7.
- Overflow: DIV 32'h80000000 / 32'hFFFFFFFF -> result=32'h80000000 after 1 cycle; REM same -> 0. DIVU same operands takes the normal 33-cycle path -> result=0.
- flush asserted at RUN cycle 10 -> busy=0 next cycle, no valid pulse. A new DIVU 9/2 issued afterwards -> result=4. A start pulse mid-RUN on a separate run is ignored, with the original result intact.
- rst asserted mid-RUN (cycle 20) -> all outputs 0 next cycle, state IDLE; a subsequent op completes with correct latency and value.
